// File: rtl/decoder_pkg.sv
// Shared decoder types: the bus word plus the UART receiver state encoding.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package decoder_pkg;

  typedef logic [31:0] word;

  localparam int UartDataBits = 8;
  localparam int UartIdxBits  = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_rx_state_t;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UartDataBits-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous input pins.
// Both stages reset to RESET_VAL so the pin reads as its idle level after reset.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture; the first stage may go metastable.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output register and
// framing/overrun pulses. Define UART_RX_PARITY_EN for an even-parity bit.
module uart_rx
  import decoder_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] prescaler,
  input  logic        rx,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        ready,
  output logic        frame_err,
`ifdef UART_RX_PARITY_EN
  output logic        parity_err,
`endif
  output logic        overrun
);

  uart_rx_state_t state_r, state_nxt_s;

  word                     cnt_r, cnt_nxt_s;
  logic [UartIdxBits-1:0]  bit_idx_r, bit_idx_nxt_s;
  logic [UartDataBits-1:0] shreg_r, shreg_nxt_s;
  logic [UartDataBits-1:0] data_r, data_nxt_s;
  logic                    valid_r, valid_nxt_s;
  logic                    frame_err_r, frame_err_nxt_s;
  logic                    overrun_r, overrun_nxt_s;
`ifdef UART_RX_PARITY_EN
  logic                    parity_err_r, parity_err_nxt_s;
  logic                    par_bit_r, par_bit_nxt_s;
`endif

  logic rx_sync_s;
  logic rx_sync_q_r;
  logic tick_s;
  logic rx_fall_s;
  logic parity_bad_s;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d       (rx),
    .q       (rx_sync_s)
  );

  // One-cycle delayed copy of the synchronized line for edge detection.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rx_sync_q_r <= 1'b1;
    end else begin
      rx_sync_q_r <= rx_sync_s;
    end
  end

  assign tick_s    = (cnt_r == 32'd0);
  assign rx_fall_s = rx_sync_q_r & ~rx_sync_s;

  // Parity check against the captured byte; constant clear without the option.
  always_comb begin
`ifdef UART_RX_PARITY_EN
    parity_bad_s = (even_parity(shreg_r) != par_bit_r);
`else
    parity_bad_s = 1'b0;
`endif
  end

  // Next-state, bit timer, shifter and output register logic.
  // Bits are taken from the delayed copy: the edge costs one cycle to detect,
  // and this keeps the sample point inside the bit even at prescaler 0.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    bit_idx_nxt_s   = bit_idx_r;
    shreg_nxt_s     = shreg_r;
    data_nxt_s      = data_r;
    valid_nxt_s     = valid_r & ~ready;
    frame_err_nxt_s = 1'b0;
    overrun_nxt_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_nxt_s = 1'b0;
    par_bit_nxt_s    = par_bit_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (rx_fall_s) begin
          cnt_nxt_s   = prescaler >> 1;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (tick_s) begin
          cnt_nxt_s = prescaler;
          if (rx_sync_q_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            bit_idx_nxt_s = {UartIdxBits{1'b0}};
            state_nxt_s   = ST_DATA;
          end
        end else begin
          cnt_nxt_s = cnt_r - 32'd1;
        end
      end

      ST_DATA: begin
        if (tick_s) begin
          cnt_nxt_s   = prescaler;
          shreg_nxt_s = {rx_sync_q_r, shreg_r[UartDataBits-1:1]};
          if (bit_idx_r == UartIdxBits'(UartDataBits - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            state_nxt_s = ST_STOP;
`endif
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r - 32'd1;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          cnt_nxt_s     = prescaler;
          par_bit_nxt_s = rx_sync_q_r;
          state_nxt_s   = ST_STOP;
        end else begin
          cnt_nxt_s = cnt_r - 32'd1;
        end
      end
`endif

      ST_STOP: begin
        if (tick_s) begin
          frame_err_nxt_s = ~rx_sync_q_r;
`ifdef UART_RX_PARITY_EN
          parity_err_nxt_s = parity_bad_s;
`endif
          if (rx_sync_q_r && !parity_bad_s) begin
            if (!valid_r || ready) begin
              data_nxt_s  = shreg_r;
              valid_nxt_s = 1'b1;
            end else begin
              overrun_nxt_s = 1'b1;
            end
          end else begin
            data_nxt_s = data_r;
          end
          // A start edge arriving with the stop sample begins the next frame.
          if (rx_fall_s) begin
            cnt_nxt_s   = prescaler >> 1;
            state_nxt_s = ST_START;
          end else begin
            cnt_nxt_s   = prescaler;
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r - 32'd1;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_r       <= 32'd0;
      bit_idx_r   <= {UartIdxBits{1'b0}};
      shreg_r     <= {UartDataBits{1'b0}};
      data_r      <= {UartDataBits{1'b0}};
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
      par_bit_r    <= 1'b0;
`endif
    end else begin
      cnt_r       <= cnt_nxt_s;
      bit_idx_r   <= bit_idx_nxt_s;
      shreg_r     <= shreg_nxt_s;
      data_r      <= data_nxt_s;
      valid_r     <= valid_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      overrun_r   <= overrun_nxt_s;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= parity_err_nxt_s;
      par_bit_r    <= par_bit_nxt_s;
`endif
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-computed frames, handshakes and error pulses.
// Build with UART_RX_PARITY_EN to also exercise the parity option.
module tb_uart_rx;
  import decoder_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] prescaler;
  logic        rx;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        frame_err;
  logic        overrun;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif

  uart_rx dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .prescaler (prescaler),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Observation counters, sampled on the active edge before the DUT updates.
  int         cyc = 0;
  logic [7:0] hs_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;
  int         valid_cycles = 0;
  int         rise_cyc = -1;
  logic       valid_d = 1'b0;

  always @(posedge clk_i) begin
    if (valid === 1'b1 && ready === 1'b1) hs_q.push_back(data);
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
`endif
    if (valid === 1'b1) valid_cycles <= valid_cycles + 1;
    if (valid === 1'b1 && valid_d !== 1'b1) rise_cyc <= cyc;
    valid_d <= valid;
    cyc     <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Drives one frame LSB first, each bit held p+1 cycles; rx keeps the stop level.
  task automatic send_frame(input logic [7:0] b, input int p, input logic stop_bit,
                            input logic par_flip);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop_bit, (^b) ^ par_flip, b, 1'b0};
`else
    bits = {par_flip, stop_bit, b, 1'b0};
`endif
    for (int i = 0; i < FrameBits; i++) begin
      rx = bits[i];
      repeat (p + 1) @(negedge clk_i);
    end
  endtask

  int n0, hs0, fe0, ov0, pe0, vc0;

  initial begin
    reset_i   = 1'b0;
    rx        = 1'b1;
    ready     = 1'b0;
    prescaler = 32'd3;
    idle(3);
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
`ifdef UART_RX_PARITY_EN
    check("reset_parity_err", parity_err, 1'b0);
`endif
    reset_i = 1'b1;
    idle(5);

    // Single byte at P=3: valid rises 4 + 1 + FrameBits-1 bit periods after start.
    ready = 1'b1;
    hs0 = hs_q.size(); vc0 = valid_cycles; n0 = cyc;
    send_frame(8'hA5, 3, 1'b1, 1'b0);
    idle(10);
    check("rx_a5_rise_cycle", rise_cyc, n0 + 5 + (FrameBits - 1) * 4);
    check("rx_a5_count", hs_q.size() - hs0, 1);
    check("rx_a5_data", hs_q[hs0], 8'hA5);
    check("rx_a5_valid_cycles", valid_cycles - vc0, 1);

    // Back-to-back frames at P=0 with no gap.
    prescaler = 32'd0;
    idle(4);
    hs0 = hs_q.size(); fe0 = fe_cnt;
    send_frame(8'h00, 0, 1'b1, 1'b0);
    send_frame(8'hFF, 0, 1'b1, 1'b0);
    send_frame(8'h55, 0, 1'b1, 1'b0);
    idle(20);
    check("b2b_count", hs_q.size() - hs0, 3);
    check("b2b_byte0", hs_q[hs0], 8'h00);
    check("b2b_byte1", hs_q[hs0 + 1], 8'hFF);
    check("b2b_byte2", hs_q[hs0 + 2], 8'h55);
    check("b2b_no_frame_err", fe_cnt - fe0, 0);

    // Start glitch at P=7: two low cycles, then high.
    prescaler = 32'd7;
    idle(4);
    hs0 = hs_q.size(); fe0 = fe_cnt; vc0 = valid_cycles;
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(30);
    check("glitch_no_valid", valid_cycles - vc0, 0);
    check("glitch_no_frame_err", fe_cnt - fe0, 0);
    check("glitch_state_idle", 32'(dut.state_r), 32'(ST_IDLE));

    // Framing error at P=3, then a long low line that must not start a frame.
    prescaler = 32'd3;
    idle(4);
    hs0 = hs_q.size(); fe0 = fe_cnt; vc0 = valid_cycles;
    send_frame(8'h3C, 3, 1'b0, 1'b0);
    idle(20);
    check("ferr_pulse", fe_cnt - fe0, 1);
    check("ferr_no_valid", valid_cycles - vc0, 0);
    check("ferr_low_state_idle", 32'(dut.state_r), 32'(ST_IDLE));
    rx = 1'b1;
    idle(40);
    check("ferr_release_no_frame_err", fe_cnt - fe0, 1);
    check("ferr_release_no_valid", valid_cycles - vc0, 0);
    check("ferr_release_no_handshake", hs_q.size() - hs0, 0);

    // Overrun: consumer stalled across two frames.
    ready = 1'b0;
    hs0 = hs_q.size(); ov0 = ov_cnt;
    send_frame(8'h11, 3, 1'b1, 1'b0);
    idle(5);
    check("ovr_first_no_pulse", ov_cnt - ov0, 0);
    send_frame(8'h22, 3, 1'b1, 1'b0);
    idle(10);
    check("ovr_pulse", ov_cnt - ov0, 1);
    check("ovr_data_kept", data, 8'h11);
    check("ovr_valid_held", valid, 1'b1);
    check("ovr_no_handshake", hs_q.size() - hs0, 0);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    idle(5);
    check("ovr_one_handshake", hs_q.size() - hs0, 1);
    check("ovr_handshake_data", hs_q[hs0], 8'h11);
    check("ovr_valid_cleared", valid, 1'b0);

    // Reset during DATA bit 4 with a byte pending in the output register.
    send_frame(8'h3C, 3, 1'b1, 1'b0);
    idle(5);
    check("rst_pre_valid", valid, 1'b1);
    check("rst_pre_data", data, 8'h3C);
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_frame(8'hF8, 3, 1'b1, 1'b0);
      begin
        idle(21);
        reset_i = 1'b0;
        idle(1);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_state_idle", 32'(dut.state_r), 32'(ST_IDLE));
        reset_i = 1'b1;
      end
    join
    idle(10);
    check("rst_partial_no_valid", valid, 1'b0);
    check("rst_partial_no_frame_err", fe_cnt - fe0, 0);
    ready = 1'b1;
    hs0 = hs_q.size();
    send_frame(8'h81, 3, 1'b1, 1'b0);
    idle(10);
    check("rst_after_count", hs_q.size() - hs0, 1);
    check("rst_after_data", hs_q[hs0], 8'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit is 1.
    hs0 = hs_q.size(); pe0 = pe_cnt;
    send_frame(8'h07, 3, 1'b1, 1'b0);
    idle(10);
    check("par_ok_count", hs_q.size() - hs0, 1);
    check("par_ok_data", hs_q[hs0], 8'h07);
    check("par_ok_no_err", pe_cnt - pe0, 0);
    hs0 = hs_q.size(); vc0 = valid_cycles;
    send_frame(8'h07, 3, 1'b1, 1'b1);
    idle(10);
    check("par_bad_pulse", pe_cnt - pe0, 1);
    check("par_bad_no_valid", valid_cycles - vc0, 0);
    check("par_bad_no_handshake", hs_q.size() - hs0, 0);
`else
    pe0 = pe_cnt;
    check("no_parity_pulses", pe_cnt - pe0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
